// File: rtl/vignette_bayer.sv
// vignette_bayer: pipelined lens-shading (vignette) corrector for the dtype-tagged
// pixel stream. Each pixel is scaled by separable column and row gains that are
// linearly interpolated from subsampled coefficient tables, with one table pair
// per Bayer phase. Coefficients load over the di register interface.
//
// Optional feature macro: VIGNETTE_BAYER_READBACK_EN
//   defined   -> di_reg_datao returns the addressed table entry (combinational read port)
//   undefined -> di_reg_datao is tied to zero and no read port exists
//
// Latency is a fixed two cycles for every beat:
//   stage 1: table lookup + interpolation, register gains, pixel, dtype, valid
//   stage 2: multiply, clamp, register outputs

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hF0
`endif
`ifndef TERM_VignetteCol
`define TERM_VignetteCol 16'h0040
`endif
`ifndef TERM_VignetteRow
`define TERM_VignetteRow 16'h0041
`endif

module vignette_bayer #(
  parameter int PIXEL_WIDTH     = 10,
  parameter int DIM_WIDTH       = 11,
  parameter int NUM_ROWS        = 728,
  parameter int NUM_COLS        = 1286,
  parameter int GAIN_WIDTH      = 10,
  parameter int GAIN_FRAC_WIDTH = 8,
  parameter int SUBSAMPLE_SHIFT = 4,
  parameter int NUM_CHANNELS    = 4
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic [15:0]             di_term_addr,
  input  logic [31:0]             di_reg_addr,
  input  logic                    di_read_mode,
  input  logic                    di_read_req,
  input  logic                    di_read,
  input  logic                    di_write_mode,
  input  logic                    di_write,
  input  logic [31:0]             di_reg_datai,
  output logic                    di_read_rdy,
  output logic                    di_write_rdy,
  output logic [31:0]             di_reg_datao,
  output logic [15:0]             di_transfer_status,
  output logic                    di_en,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [15:0]             datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]             datao
);

  localparam int S            = SUBSAMPLE_SHIFT;
  localparam int SUB_NUM_COLS = (NUM_COLS + (1 << S) - 1) >> S;
  localparam int SUB_NUM_ROWS = (NUM_ROWS + (1 << S) - 1) >> S;
  localparam int CIDX_W       = (SUB_NUM_COLS > 1) ? $clog2(SUB_NUM_COLS) : 1;
  localparam int RIDX_W       = (SUB_NUM_ROWS > 1) ? $clog2(SUB_NUM_ROWS) : 1;
  localparam int AIDX_W       = DIM_WIDTH - S;
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PROD_W       = PIXEL_WIDTH + 2 * GAIN_WIDTH;
  localparam int SHIFT_W      = 2 * GAIN_FRAC_WIDTH;
  // Interpolation works in a signed width wide enough that diff*dx never overflows.
  localparam int IW           = GAIN_WIDTH + S + 2;

  localparam logic [DIM_WIDTH-1:0] COL_LAST    = DIM_WIDTH'(SUB_NUM_COLS - 1);
  localparam logic [DIM_WIDTH-1:0] ROW_LAST    = DIM_WIDTH'(SUB_NUM_ROWS - 1);
  localparam logic [AIDX_W:0]      COL_LIMIT   = (AIDX_W + 1)'(SUB_NUM_COLS);
  localparam logic [AIDX_W:0]      ROW_LIMIT   = (AIDX_W + 1)'(SUB_NUM_ROWS);
  localparam logic [2:0]           CH_LIMIT    = 3'(NUM_CHANNELS);

  // y0 + ((y1 - y0) * dx >>> S); the arithmetic shift keeps the result between y0 and y1
  function automatic logic [GAIN_WIDTH-1:0] interp(input logic [GAIN_WIDTH-1:0] y0,
                                                   input logic [GAIN_WIDTH-1:0] y1,
                                                   input logic [S-1:0]          dx);
    logic signed [IW-1:0] diff;
    logic signed [IW-1:0] step;
    diff = $signed(IW'(y1)) - $signed(IW'(y0));
    step = (diff * $signed(IW'(dx))) >>> S;
    return GAIN_WIDTH'(IW'(y0) + step);
  endfunction

  // coefficient storage, intentionally not reset
  logic [GAIN_WIDTH-1:0] col_tab [NUM_CHANNELS][SUB_NUM_COLS];
  logic [GAIN_WIDTH-1:0] row_tab [NUM_CHANNELS][SUB_NUM_ROWS];

  logic                  term_col;
  logic                  term_row;
  logic [AIDX_W-1:0]     addr_idx;
  logic [1:0]            addr_ch;
  logic                  ch_ok;
  logic                  col_idx_ok;
  logic                  row_idx_ok;
  logic [CH_W-1:0]       wr_ch;
  logic [CIDX_W-1:0]     wr_cidx;
  logic [RIDX_W-1:0]     wr_ridx;
  logic                  wr_en;

  assign term_col   = (di_term_addr == `TERM_VignetteCol);
  assign term_row   = (di_term_addr == `TERM_VignetteRow);
  assign di_en      = term_col | term_row;
  assign addr_idx   = di_reg_addr[AIDX_W-1:0];
  assign addr_ch    = di_reg_addr[17:16];
  assign ch_ok      = ({1'b0, addr_ch} < CH_LIMIT);
  assign col_idx_ok = ({1'b0, addr_idx} < COL_LIMIT);
  assign row_idx_ok = ({1'b0, addr_idx} < ROW_LIMIT);
  assign wr_ch      = CH_W'(addr_ch);
  assign wr_cidx    = CIDX_W'(addr_idx);
  assign wr_ridx    = RIDX_W'(addr_idx);
  assign wr_en      = di_en & di_write & ch_ok;

  assign di_read_rdy        = 1'b1;
  assign di_write_rdy       = 1'b1;
  assign di_transfer_status = 16'h0000;

  // column coefficient writes; out-of-range channel or index is dropped
  always_ff @(posedge clk) begin
    if (wr_en && term_col && col_idx_ok)
      col_tab[wr_ch][wr_cidx] <= di_reg_datai[GAIN_WIDTH-1:0];
  end

  // row coefficient writes; out-of-range channel or index is dropped
  always_ff @(posedge clk) begin
    if (wr_en && term_row && row_idx_ok)
      row_tab[wr_ch][wr_ridx] <= di_reg_datai[GAIN_WIDTH-1:0];
  end

`ifdef VIGNETTE_BAYER_READBACK_EN
  // combinational readback of the addressed coefficient
  always_comb begin
    di_reg_datao = '0;
    if (term_col && ch_ok && col_idx_ok)
      di_reg_datao = 32'(col_tab[wr_ch][wr_cidx]);
    else if (term_row && ch_ok && row_idx_ok)
      di_reg_datao = 32'(row_tab[wr_ch][wr_ridx]);
  end
`else
  assign di_reg_datao = '0;
`endif

  logic [DIM_WIDTH-1:0] row_pos;
  logic [DIM_WIDTH-1:0] col_pos;
  logic                 is_pix;

  assign is_pix = |(dtypei & `DTYPE_PIXEL_MASK);

  // raster position tracking, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!resetb) begin
      row_pos <= '0;
      col_pos <= '0;
    end else if (dvi) begin
      if (dtypei == `DTYPE_FRAME_START)
        row_pos <= '0;
      else if (dtypei == `DTYPE_ROW_END && row_pos != '1)
        row_pos <= row_pos + DIM_WIDTH'(1);
      if (dtypei == `DTYPE_ROW_START)
        col_pos <= '0;
      else if (is_pix && col_pos != '1)
        col_pos <= col_pos + DIM_WIDTH'(1);
    end
  end

  logic [CH_W-1:0]       pix_ch;
  logic [DIM_WIDTH-1:0]  col_blk;
  logic [DIM_WIDTH-1:0]  row_blk;
  logic [CIDX_W-1:0]     c_i0;
  logic [CIDX_W-1:0]     c_i1;
  logic [RIDX_W-1:0]     r_i0;
  logic [RIDX_W-1:0]     r_i1;
  logic [GAIN_WIDTH-1:0] cg_next;
  logic [GAIN_WIDTH-1:0] rg_next;

  assign pix_ch = (NUM_CHANNELS == 4) ? CH_W'({row_pos[0], col_pos[0]}) : '0;

  // grid cell selection; past the last grid point both neighbours are the last entry
  always_comb begin
    col_blk = col_pos >> S;
    row_blk = row_pos >> S;
    c_i0    = CIDX_W'(COL_LAST);
    c_i1    = CIDX_W'(COL_LAST);
    r_i0    = RIDX_W'(ROW_LAST);
    r_i1    = RIDX_W'(ROW_LAST);
    if (col_blk < COL_LAST) begin
      c_i0 = CIDX_W'(col_blk);
      c_i1 = CIDX_W'(col_blk + DIM_WIDTH'(1));
    end
    if (row_blk < ROW_LAST) begin
      r_i0 = RIDX_W'(row_blk);
      r_i1 = RIDX_W'(row_blk + DIM_WIDTH'(1));
    end
  end

  assign cg_next = interp(col_tab[pix_ch][c_i0], col_tab[pix_ch][c_i1], col_pos[S-1:0]);
  assign rg_next = interp(row_tab[pix_ch][r_i0], row_tab[pix_ch][r_i1], row_pos[S-1:0]);

  logic                    s1_dv;
  logic [`DTYPE_WIDTH-1:0] s1_dtype;
  logic [15:0]             s1_data;
  logic                    s1_apply;
  logic [GAIN_WIDTH-1:0]   s1_cg;
  logic [GAIN_WIDTH-1:0]   s1_rg;

  // stage 1: capture interpolated gains alongside the beat; enable is sampled here
  always_ff @(posedge clk) begin
    if (!resetb) begin
      s1_dv    <= 1'b0;
      s1_dtype <= '0;
      s1_data  <= '0;
      s1_apply <= 1'b0;
      s1_cg    <= '0;
      s1_rg    <= '0;
    end else begin
      s1_dv    <= dvi;
      s1_dtype <= dtypei;
      s1_data  <= datai;
      s1_apply <= enable & is_pix;
      s1_cg    <= cg_next;
      s1_rg    <= rg_next;
    end
  end

  logic [PROD_W-1:0]      prod;
  logic                   over;
  logic [PIXEL_WIDTH-1:0] pix_out;
  logic [15:0]            gained;

  assign prod    = PROD_W'(s1_data[PIXEL_WIDTH-1:0]) * PROD_W'(s1_cg) * PROD_W'(s1_rg);
  assign over    = |prod[PROD_W-1:SHIFT_W+PIXEL_WIDTH];
  assign pix_out = over ? '1 : prod[SHIFT_W +: PIXEL_WIDTH];
  assign gained  = 16'(pix_out);

  // stage 2: apply gain or pass through; idle beats leave datao/dtypeo holding
  always_ff @(posedge clk) begin
    if (!resetb) begin
      dvo    <= 1'b0;
      dtypeo <= '0;
      datao  <= '0;
    end else begin
      dvo <= s1_dv;
      if (s1_dv) begin
        dtypeo <= s1_dtype;
        datao  <= s1_apply ? gained : s1_data;
      end
    end
  end

  // strobes and address/data bits that this block does not decode
  logic unused_di;
  assign unused_di = ^{di_read_mode, di_read_req, di_read, di_write_mode,
                       di_reg_addr, di_reg_datai, prod[SHIFT_W-1:0]};

endmodule

// File: tb/tb_vignette_bayer.sv
// Scoreboard bench for vignette_bayer: stimulus pushes expected beats from a
// plain-arithmetic reference model, a monitor pops and compares on dvo.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hF0
`endif
`ifndef TERM_VignetteCol
`define TERM_VignetteCol 16'h0040
`endif
`ifndef TERM_VignetteRow
`define TERM_VignetteRow 16'h0041
`endif

module tb_vignette_bayer;
  localparam logic [7:0] DT_FS  = `DTYPE_FRAME_START;
  localparam logic [7:0] DT_RS  = `DTYPE_ROW_START;
  localparam logic [7:0] DT_RE  = `DTYPE_ROW_END;
  localparam logic [7:0] DT_PIX = 8'h10;
  localparam logic [7:0] DT_OTH = 8'h0C;
  localparam int SUBC = 81;
  localparam int SUBR = 46;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic enable = 1'b0;
  logic [15:0] di_term_addr = 16'h0;
  logic [31:0] di_reg_addr = 32'h0;
  logic di_read_mode = 1'b0, di_read_req = 1'b0, di_read = 1'b0, di_write_mode = 1'b0;
  logic di_write = 1'b0;
  logic [31:0] di_reg_datai = 32'h0;
  logic di_read_rdy, di_write_rdy, di_en;
  logic [31:0] di_reg_datao;
  logic [15:0] di_transfer_status;
  logic dvi = 1'b0;
  logic [`DTYPE_WIDTH-1:0] dtypei = '0;
  logic [15:0] datai = 16'h0;
  logic dvo;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [15:0] datao;

  vignette_bayer dut (
    .clk(clk), .resetb(resetb), .enable(enable),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
    .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
    .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy), .di_reg_datao(di_reg_datao),
    .di_transfer_status(di_transfer_status), .di_en(di_en),
    .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0]  dt;
    logic [15:0] d;
    int          t;
  } exp_t;
  exp_t sb[$];

  // reference model state
  int mcol[4][SUBC];
  int mrow[4][SUBR];
  int m_row = 0;
  int m_col = 0;

  bit wr_pend = 0;
  bit wr_col = 0;
  int wr_ch = 0, wr_idx = 0, wr_val = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // gain at position p along one axis: linear interpolation between grid points 16 apart
  function automatic int gain_m(input bit is_col, input int ch, input int p);
    int sub, i0, i1, dx, y0, y1, t, q;
    sub = is_col ? SUBC : SUBR;
    i0 = p / 16;
    dx = p % 16;
    if (i0 > sub - 1) i0 = sub - 1;
    i1 = (i0 + 1 > sub - 1) ? sub - 1 : i0 + 1;
    y0 = is_col ? mcol[ch][i0] : mrow[ch][i0];
    y1 = is_col ? mcol[ch][i1] : mrow[ch][i1];
    t = (y1 - y0) * dx;
    q = (t >= 0) ? t / 16 : -((-t + 15) / 16);
    return y0 + q;
  endfunction

  function automatic int model_pix(input logic [7:0] dt, input logic [15:0] d, input bit en);
    int ch, cg, rg;
    longint pr;
    if (!en || (dt & `DTYPE_PIXEL_MASK) == 0) return int'(d);
    ch = (m_row % 2) * 2 + (m_col % 2);
    cg = gain_m(1'b1, ch, m_col);
    rg = gain_m(1'b0, ch, m_row);
    pr = (longint'(d[9:0]) * cg * rg) / 65536;
    return (pr > 1023) ? 1023 : int'(pr);
  endfunction

  // one input cycle; force_exp >= 0 replaces the model value with a hand-derived constant
  task automatic beat(input bit v, input logic [7:0] dt, input logic [15:0] d,
                      input bit en, input int force_exp = -1);
    exp_t e;
    @(negedge clk);
    dvi = v; dtypei = dt; datai = d; enable = en; di_write = 1'b0;
    if (wr_pend) begin
      di_write = 1'b1;
      di_term_addr = wr_col ? `TERM_VignetteCol : `TERM_VignetteRow;
      di_reg_addr = {14'h0, 2'(wr_ch), 16'(wr_idx)};
      di_reg_datai = 32'(wr_val);
    end
    if (v) begin
      e.dt = dt;
      e.d = 16'(model_pix(dt, d, en));
      if (force_exp >= 0) e.d = 16'(force_exp);
      e.t = cyc;
      sb.push_back(e);
      if (dt == DT_FS) m_row = 0;
      else if (dt == DT_RE && m_row < 2047) m_row++;
      if (dt == DT_RS) m_col = 0;
      else if ((dt & `DTYPE_PIXEL_MASK) != 0 && m_col < 2047) m_col++;
    end
    if (wr_pend) begin
      if (wr_col && wr_idx < SUBC) mcol[wr_ch][wr_idx] = wr_val;
      if (!wr_col && wr_idx < SUBR) mrow[wr_ch][wr_idx] = wr_val;
      wr_pend = 0;
    end
  endtask

  task automatic wr(input bit col, input int ch, input int idx, input int val);
    wr_pend = 1; wr_col = col; wr_ch = ch; wr_idx = idx; wr_val = val;
    beat(1'b0, 8'h00, 16'h0, 1'b1);
  endtask

  task automatic fill_all(input int cval, input int rval);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < SUBC; i++) wr(1'b1, c, i, cval);
      for (int i = 0; i < SUBR; i++) wr(1'b0, c, i, rval);
    end
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < SUBC; i++) wr(1'b1, c, i, int'($urandom_range(hi, lo)));
      for (int i = 0; i < SUBR; i++) wr(1'b0, c, i, int'($urandom_range(hi, lo)));
    end
  endtask

  // monitor: every output beat must match the oldest pending expectation, two cycles after issue
  always @(negedge clk) begin
    exp_t e;
    if (dvo) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got dvo=1 datao=%0d, expected no output", datao);
      end else begin
        e = sb.pop_front();
        check("dtypeo", longint'(dtypeo), longint'(e.dt));
        check("datao", longint'(datao), longint'(e.d));
        check("latency", longint'(cyc - e.t), 2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset values and tied outputs
    repeat (3) @(negedge clk);
    check("rst_dvo", dvo, 0);
    check("rst_dtypeo", dtypeo, 0);
    check("rst_datao", datao, 0);
    check("read_rdy", di_read_rdy, 1);
    check("write_rdy", di_write_rdy, 1);
    check("xfer_status", di_transfer_status, 0);
    di_term_addr = `TERM_VignetteRow; #1;
    check("di_en_row", di_en, 1);
    di_term_addr = 16'h1234; #1;
    check("di_en_other", di_en, 0);
    resetb = 1'b1;

    // unity gains: ramp passes unchanged
    fill_all(256, 256);
    beat(1, DT_FS, 0, 1);
    beat(1, DT_RS, 0, 1);
    for (int p = 0; p < 1024; p++) begin
      if (p % 256 == 0 && p > 0) begin
        beat(1, DT_RE, 0, 1);
        beat(1, DT_RS, 0, 1);
      end
      beat(1, DT_PIX, 16'(p), 1, p);
    end

    // interpolation halfway between 256 and 512, then the descending case
    wr(1'b1, 0, 0, 256);
    wr(1'b1, 0, 1, 512);
    beat(1, DT_FS, 0, 1);
    beat(1, DT_RS, 0, 1);
    for (int p = 0; p < 8; p++) beat(1, DT_PIX, 16'd100, 1);
    beat(1, DT_PIX, 16'd100, 1, 150);
    wr(1'b1, 0, 0, 512);
    wr(1'b1, 0, 1, 256);
    beat(1, DT_RS, 0, 1);
    for (int p = 0; p < 8; p++) beat(1, DT_PIX, 16'd100, 1);
    beat(1, DT_PIX, 16'd100, 1, 150);

    // per-phase column gains
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < SUBC; i++) wr(1'b1, c, i, 256 + 64 * c);
    beat(1, DT_FS, 0, 1);
    beat(1, DT_RS, 0, 1);
    beat(1, DT_PIX, 16'd200, 1, 200);
    beat(1, DT_PIX, 16'd200, 1, 250);
    beat(1, DT_RE, 0, 1);
    beat(1, DT_RS, 0, 1);
    beat(1, DT_PIX, 16'd200, 1, 300);
    beat(1, DT_PIX, 16'd200, 1, 350);

    // clamp at full scale
    fill_all(1023, 1023);
    beat(1, DT_FS, 0, 1);
    beat(1, DT_RS, 0, 1);
    beat(1, DT_PIX, 16'd1023, 1, 1023);
    beat(1, DT_PIX, 16'd1, 1);
    beat(1, DT_PIX, 16'd64, 1);

    // long row past NUM_COLS, random tables
    fill_rand(128, 600);
    beat(1, DT_FS, 0, 1);
    repeat (3) beat(1, DT_RE, 0, 1);
    beat(1, DT_RS, 0, 1);
    for (int p = 0; p < 1300; p++) begin
      if ($urandom_range(7, 0) == 0) beat(0, 8'h00, 16'h0, 1);
      beat(1, DT_PIX, 16'($urandom_range(1023, 0)), 1);
    end

    // row counter saturation
    beat(1, DT_FS, 0, 1);
    repeat (2100) beat(1, DT_RE, 0, 1);
    beat(1, DT_RS, 0, 1);
    repeat (40) beat(1, DT_PIX, 16'($urandom_range(1023, 0)), 1);

    // random frame: short rows through every row position, gaps, enable toggling, live writes
    fill_rand(0, 1023);
    beat(1, DT_FS, 0, 1);
    for (int r = 0; r < 780; r++) begin
      beat(1, DT_RS, 0, 1);
      n = int'($urandom_range(4, 1));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(7, 0) == 0) begin
          wr_pend = 1; wr_col = $urandom_range(1, 0) != 0; wr_ch = int'($urandom_range(3, 0));
          wr_idx = int'($urandom_range(wr_col ? SUBC - 1 : SUBR - 1, 0));
          wr_val = int'($urandom_range(1023, 0));
        end
        if ($urandom_range(9, 0) == 0) beat(0, DT_PIX, 16'($urandom), 1);
        if ($urandom_range(9, 0) == 0) beat(1, DT_OTH, 16'($urandom), 1);
        beat(1, DT_PIX, 16'($urandom), $urandom_range(5, 0) != 0);
      end
      beat(1, DT_RE, 0, 1);
    end

    // bypass: full 16-bit data passes with enable low
    beat(1, DT_RS, 0, 0);
    repeat (50) beat(1, DT_PIX, 16'($urandom), 0);

    // readback
    wr(1'b1, 2, 5, 'h155);
    @(negedge clk);
    di_write = 1'b0;
    di_term_addr = `TERM_VignetteCol;
    di_reg_addr = {14'h0, 2'd2, 16'd5};
    #1;
`ifdef VIGNETTE_BAYER_READBACK_EN
    check("readback", di_reg_datao, 'h155);
`else
    check("readback", di_reg_datao, 0);
`endif

    // reset mid-row: outputs clear on the next edge, counters restart
    beat(1, DT_FS, 0, 1);
    beat(1, DT_RS, 0, 1);
    repeat (5) beat(1, DT_PIX, 16'($urandom_range(1023, 100)), 1);
    @(negedge clk);
    resetb = 1'b0; dvi = 1'b0;
    @(negedge clk);
    check("midrst_dvo", dvo, 0);
    check("midrst_dtypeo", dtypeo, 0);
    check("midrst_datao", datao, 0);
    sb.delete();
    m_row = 0; m_col = 0;
    resetb = 1'b1;
    beat(1, DT_FS, 0, 1);
    beat(1, DT_RS, 0, 1);
    repeat (3) beat(1, DT_PIX, 16'($urandom_range(1023, 0)), 1);
    beat(1, DT_RE, 0, 1);
    beat(1, DT_RS, 0, 1);
    repeat (3) beat(1, DT_PIX, 16'($urandom_range(1023, 0)), 1);

    // drain
    repeat (4) beat(0, 8'h00, 16'h0, 1);
    check("drain_pending", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
